alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_mul.sv | 61 ++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and sizing definitions for the sequential ALU.
// Consumed by alu_seq and alu_seq_mul (the latter built only with ALU_SEQ_MUL_EN).
package alu_pkg;

  localparam int ALU_W     = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5,
    NOT = 3'd6,
    SHL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, one-cycle o_done pulse.
// Instantiated by alu_seq only when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int ITERS = MUL_ITERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(ITERS);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic               r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_mcand  <= {{WIDTH{1'b0}}, i_a};
        r_mplier <= i_b;
        r_prod   <= '0;
        r_cnt    <= '0;
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_mplier[0]) begin
          r_prod <= r_prod + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CW'(ITERS - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done    = r_done;
  assign o_product = r_prod;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: valid/ready request in, held 2*WIDTH result out.
// Optional iterative multiplier enabled by defining ALU_SEQ_MUL_EN; otherwise MUL reports err.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     P,
  input  logic [WIDTH-1:0]     Q,
  input  logic [2:0]           sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   Acc,
  output logic                 err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t         r_state;
  alu_state_t         w_state_next;
  logic [WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]   r_q;
  alu_op_t            r_sel;
  logic               r_pend;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_err;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic               w_op_err;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;

  // r_pend marks operands captured last edge; the result is loaded on the next edge.
  assign in_ready = (r_state == IDLE) && !r_pend && !rst;
  assign w_accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic w_mul_start;

  assign w_is_mul    = (alu_op_t'(sel) == MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_op_err    = 1'b0;

  alu_seq_mul #(
    .WIDTH (WIDTH),
    .ITERS (MUL_ITERS)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (P),
    .i_b       (Q),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
  assign w_op_err   = (r_sel == MUL);
`endif

  always_comb begin
    w_sum    = {1'b0, r_p} + {1'b0, r_q};
    w_diff   = r_p - r_q;
    w_result = '0;
    case (r_sel)
      ADD:     w_result = {{(WIDTH-1){1'b0}}, w_sum};
      SUB:     w_result = {{WIDTH{w_diff[WIDTH-1]}}, w_diff};
      AND:     w_result = {{WIDTH{1'b0}}, r_p & r_q};
      OR:      w_result = {{WIDTH{1'b0}}, r_p | r_q};
      XOR:     w_result = {{WIDTH{1'b0}}, r_p ^ r_q};
      NOT:     w_result = {{WIDTH{1'b0}}, ~r_p};
      SHL:     w_result = {{WIDTH{1'b0}}, r_p} << r_q[SHW-1:0];
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_pend) begin
          w_state_next = DONE;
        end else if (w_accept && w_is_mul) begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        if (w_mul_done) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p    <= '0;
      r_q    <= '0;
      r_sel  <= ADD;
      r_pend <= 1'b0;
      r_acc  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_accept && !w_is_mul;
      if (w_accept) begin
        r_p   <= P;
        r_q   <= Q;
        r_sel <= alu_op_t'(sel);
      end
      if ((r_state == IDLE) && r_pend) begin
        r_acc <= w_result;
        r_err <= w_op_err;
      end else if ((r_state == EXEC) && w_mul_done) begin
        r_acc <= w_mul_prod;
        r_err <= 1'b0;
      end
    end
  end

  assign Acc       = r_acc;
  assign err       = r_err;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == EXEC);

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq; expectations for sel 2 follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam int   MUL_LAT = MUL_ON ? 33 : 1;
  localparam logic MUL_ERR = !MUL_ON;

  logic        clk;
  logic        rst;
  logic [31:0] P;
  logic [31:0] Q;
  logic [2:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Acc;
  logic        err;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       nm;
    logic [2:0]  s;
    logic [31:0] p;
    logic [31:0] q;
    logic [63:0] acc;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .P         (P),
    .Q         (Q),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Acc       (Acc),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] s, input logic [31:0] p,
                       input logic [31:0] q, input logic [63:0] eacc, input logic eerr,
                       input int elat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    P = p;
    Q = q;
    sel = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    P = $urandom;
    Q = $urandom;
    sel = 3'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, ".latency"}, 64'(n), 64'(elat));
    chk({nm, ".acc"}, Acc, eacc);
    chk({nm, ".err"}, 64'(err), 64'(eerr));
    chk({nm, ".in_ready_in_done"}, 64'(in_ready), 64'd0);
    $display("txn %-14s sel=%0d P=%h Q=%h Acc=%h err=%0b lat=%0d", nm, s, p, q, Acc, err, n);
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({nm, ".taken"}, 64'(out_valid), 64'd0);
      chk({nm, ".ready_again"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{"add",      3'd0, 32'd127, 32'd200, 64'd327, 1'b0, 1};
    vecs[1]  = '{"sub",      3'd1, 32'd127, 32'd200, 64'hFFFFFFFFFFFFFFB7, 1'b0, 1};
    vecs[2]  = '{"mul",      3'd2, 32'd127, 32'd200, MUL_ON ? 64'd25400 : 64'd0, MUL_ERR, MUL_LAT};
    vecs[3]  = '{"and",      3'd3, 32'd127, 32'd200, 64'd72, 1'b0, 1};
    vecs[4]  = '{"or",       3'd4, 32'd127, 32'd200, 64'd255, 1'b0, 1};
    vecs[5]  = '{"xor",      3'd5, 32'd127, 32'd200, 64'd183, 1'b0, 1};
    vecs[6]  = '{"not",      3'd6, 32'd127, 32'd200, 64'h00000000FFFFFF80, 1'b0, 1};
    vecs[7]  = '{"shl",      3'd7, 32'd127, 32'd200, 64'd32512, 1'b0, 1};
    vecs[8]  = '{"add_max",  3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1FFFFFFFE, 1'b0, 1};
    vecs[9]  = '{"mul_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 MUL_ON ? 64'hFFFFFFFE00000001 : 64'd0, MUL_ERR, MUL_LAT};
    vecs[10] = '{"sub_eq",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, 1};
    vecs[11] = '{"shl_31",   3'd7, 32'h80000000, 32'd31, 64'h4000000000000000, 1'b0, 1};
    vecs[12] = '{"shl_q33",  3'd7, 32'd127, 32'd33, 64'd254, 1'b0, 1};
    vecs[13] = '{"mul_6x7",  3'd2, 32'd6, 32'd7, MUL_ON ? 64'd42 : 64'd0, MUL_ERR, MUL_LAT};
    vecs[14] = '{"sub_neg1", 3'd1, 32'd0, 32'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1};
    vecs[15] = '{"xor_pat",  3'd5, 32'hA5A5A5A5, 32'hFFFFFFFF, 64'h5A5A5A5A, 1'b0, 1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    P = '0;
    Q = '0;
    sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.acc", Acc, 64'd0);
    chk("reset.err", 64'(err), 64'd0);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset.in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].nm, vecs[i].s, vecs[i].p, vecs[i].q, vecs[i].acc, vecs[i].e, vecs[i].lat);
    end

    // Stalled result with an extra request pulsed mid-stall.
    out_ready = 1'b0;
    do_op("stall_add", 3'd0, 32'd5, 32'd7, 64'd12, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        P = 32'd100;
        Q = 32'd100;
        sel = 3'd0;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("stall.acc", Acc, 64'd12);
      chk("stall.out_valid", 64'(out_valid), 64'd1);
      chk("stall.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall.released", 64'(out_valid), 64'd0);
    chk("stall.ready_again", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall.no_queued_result", 64'(out_valid), 64'd0);

`ifdef ALU_SEQ_MUL_EN
    // Reset during EXEC cycle 15 of a multiply.
    P = 32'd3;
    Q = 32'd4;
    sel = 3'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mulrst.busy_start", 64'(busy), 64'd1);
    repeat (14) @(posedge clk);
    #1;
    chk("mulrst.busy_c15", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mulrst.acc", Acc, 64'd0);
    chk("mulrst.err", 64'(err), 64'd0);
    chk("mulrst.out_valid", 64'(out_valid), 64'd0);
    chk("mulrst.busy", 64'(busy), 64'd0);
    chk("mulrst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("add_after_mrst", 3'd0, 32'd1, 32'd1, 64'd2, 1'b0, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("mulrst.no_stale", 64'(out_valid), 64'd0);
`endif

    // Reset while a result is stalled in DONE.
    out_ready = 1'b0;
    do_op("rst_in_done", 3'd0, 32'd9, 32'd9, 64'd18, 1'b0, 1);
    rst = 1'b1;
    #1;
    chk("donerst.acc", Acc, 64'd0);
    chk("donerst.out_valid", 64'(out_valid), 64'd0);
    chk("donerst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    do_op("add_after_drst", 3'd0, 32'd1, 32'd1, 64'd2, 1'b0, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("donerst.no_stale", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
